// File: rtl/spi_frame_ctrl_pkg.sv
// Shared definitions for the SPI frame sequencer: state encoding and counter sizing.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        XFER  = 3'd2,
        STORE = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } frameState_t;

    // Bits needed for a counter that must reach max(numBytes, gapCycles).
    function automatic int cntWidth(input int numBytes, input int gapCycles);
        int maxVal;
        maxVal = (numBytes > gapCycles) ? numBytes : gapCycles;
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/spi_gap_timer.sv
// Loadable down-counter with a zero flag; paces idle gaps between SPI bytes.
module spi_gap_timer #(
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST)
            count <= '0;
        else if (load)
            count <= loadVal;
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame sequencer: drives NUM_BYTES byte requests into the single-byte engine and
// publishes the received bytes atomically as one frame.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int NUM_BYTES  = 5,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_BYTES*8-1:0] tx_frame,
    input  logic                   busy,
    input  logic [7:0]             rx_byte,
    output logic                   get_byte,
    output logic [7:0]             tx_byte,
    output logic                   ss_n,
    output logic [NUM_BYTES*8-1:0] dout,
    output logic                   done,
    output logic                   frame_busy,
    output logic                   aborted
);

    localparam int              FW       = NUM_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if ((NUM_BYTES < 1) || (NUM_BYTES > 16) || (CNT_W < cntWidth(NUM_BYTES, GAP_CYCLES))) begin : gParamCheck
        $error("spi_frame_ctrl: NUM_BYTES out of range or CNT_W too narrow");
    end

    frameState_t      state, nextState;
    logic [CNT_W-1:0] byteCnt;
    logic [FW-1:0]    frameReg;
    logic [FW-1:0]    shiftReg;
    logic [FW-1:0]    shiftNext;
    logic             abortPend;
    logic             abandon;
    logic             gapLoad;
    logic             gapDec;
    logic             gapZero;

    spi_gap_timer #(.W(CNT_W)) uGapTimer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (gapLoad),
        .loadVal (GAP_LOAD),
        .dec     (gapDec),
        .zero    (gapZero)
    );

    assign shiftNext = (shiftReg << 8) | FW'(rx_byte);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        abandon   = 1'b0;
        gapLoad   = 1'b0;
        gapDec    = 1'b0;
        unique case (state)
            IDLE:  if (start && !abort) nextState = REQ;
            REQ: begin
                if (abort) begin
                    nextState = IDLE;
                    abandon   = 1'b1;
                end else if (busy) begin
                    nextState = XFER;
                end
            end
            // A byte in flight is always allowed to finish; a pending abort lands afterwards.
            XFER: begin
                if (!busy) begin
                    if (abort || abortPend) begin
                        nextState = IDLE;
                        abandon   = 1'b1;
                    end else begin
                        nextState = STORE;
                    end
                end
            end
            STORE: begin
                if (abort) begin
                    nextState = IDLE;
                    abandon   = 1'b1;
                end else if (byteCnt == LAST_CNT) begin
                    nextState = DONE;
                end else if (GAP_CYCLES > 0) begin
                    nextState = GAP;
                    gapLoad   = 1'b1;
                end else begin
                    nextState = REQ;
                end
            end
            GAP: begin
                if (abort) begin
                    nextState = IDLE;
                    abandon   = 1'b1;
                end else begin
                    gapDec = 1'b1;
                    if (gapZero) nextState = REQ;
                end
            end
            DONE:    if (!start) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: frame and shift registers are reset explicitly so a mid-frame reset leaves no stale data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            byteCnt   <= '0;
            frameReg  <= '0;
            shiftReg  <= '0;
            abortPend <= 1'b0;
            dout      <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state   <= nextState;
            done    <= 1'b0;
            aborted <= abandon;
            unique case (state)
                IDLE: begin
                    byteCnt   <= '0;
                    abortPend <= 1'b0;
                    if (nextState == REQ) frameReg <= tx_frame;
                end
                REQ:  if (nextState == XFER) byteCnt <= byteCnt + CNT_W'(1);
                XFER: if (abort) abortPend <= 1'b1;
                // The transmit byte moves on only after the engine has finished with it.
                STORE: begin
                    shiftReg <= shiftNext;
                    frameReg <= frameReg << 8;
                    if (nextState == DONE) begin
                        dout <= shiftNext;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign get_byte   = (state == REQ);
    assign ss_n       = (state == IDLE) || (state == DONE);
    assign frame_busy = (state != IDLE);
    assign tx_byte    = (state == IDLE) ? 8'h00 : frameReg[FW-1 -: 8];

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: three configurations share one byte-engine model.
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, start, abort;
    logic [39:0] txFrame;
    logic        engBusy;
    logic [7:0]  engRx;
    int          sel;

    logic [2:0]  startV, abortV, busyV;
    logic        getB [3];
    logic [7:0]  txB  [3];
    logic        ssN  [3];
    logic        doneV[3];
    logic        fBusy[3];
    logic        abrt [3];
    logic [39:0] dout0;
    logic [23:0] dout1;
    logic [7:0]  dout2;

    logic        mGet, mSs, mDone, mFbusy, mAbort;
    logic [7:0]  mTx;
    logic [39:0] mDout;

    for (genvar k = 0; k < 3; k++) begin : gRoute
        assign startV[k] = start && (sel == k);
        assign abortV[k] = abort && (sel == k);
        assign busyV[k]  = engBusy && (sel == k);
    end

    spi_frame_ctrl #(.NUM_BYTES(5), .GAP_CYCLES(0), .CNT_W(5)) uDut0 (
        .CLK(CLK), .RST(RST), .start(startV[0]), .abort(abortV[0]), .tx_frame(txFrame),
        .busy(busyV[0]), .rx_byte(engRx), .get_byte(getB[0]), .tx_byte(txB[0]), .ss_n(ssN[0]),
        .dout(dout0), .done(doneV[0]), .frame_busy(fBusy[0]), .aborted(abrt[0]));

    spi_frame_ctrl #(.NUM_BYTES(3), .GAP_CYCLES(4), .CNT_W(5)) uDut1 (
        .CLK(CLK), .RST(RST), .start(startV[1]), .abort(abortV[1]), .tx_frame(txFrame[23:0]),
        .busy(busyV[1]), .rx_byte(engRx), .get_byte(getB[1]), .tx_byte(txB[1]), .ss_n(ssN[1]),
        .dout(dout1), .done(doneV[1]), .frame_busy(fBusy[1]), .aborted(abrt[1]));

    spi_frame_ctrl #(.NUM_BYTES(1), .GAP_CYCLES(0), .CNT_W(5)) uDut2 (
        .CLK(CLK), .RST(RST), .start(startV[2]), .abort(abortV[2]), .tx_frame(txFrame[7:0]),
        .busy(busyV[2]), .rx_byte(engRx), .get_byte(getB[2]), .tx_byte(txB[2]), .ss_n(ssN[2]),
        .dout(dout2), .done(doneV[2]), .frame_busy(fBusy[2]), .aborted(abrt[2]));

    always_comb begin
        mGet   = getB[sel];
        mTx    = txB[sel];
        mSs    = ssN[sel];
        mDone  = doneV[sel];
        mFbusy = fBusy[sel];
        mAbort = abrt[sel];
        case (sel)
            0:       mDout = dout0;
            1:       mDout = {16'h0, dout1};
            default: mDout = {32'h0, dout2};
        endcase
    end

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int limit);
        nTests++;
        nFail++;
        $display("FAIL %s: no response within %0d cycles", name, limit);
    endtask

    int cycles = 0;
    always @(posedge CLK) cycles++;

    // Byte engine: busy rises one cycle after get_byte and stays high busyLen cycles.
    int          busyLen = 3;
    int          expGap  = 2;
    bit          forceMode = 1'b0;
    bit          forceBusy = 1'b0;
    logic [7:0]  forceRx   = 8'h00;
    logic [7:0]  rxQ[$];
    logic [7:0]  txExp[$];
    int          cnt, capIdx, lastFall, ssViol;
    bit          armed, inFrame;
    logic [7:0]  capTx;

    initial begin
        engBusy = 1'b0; engRx = 8'h00; armed = 1'b0; cnt = 0; capIdx = 0;
        lastFall = 0; inFrame = 1'b0; ssViol = 0; capTx = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST) begin
                engBusy = 1'b0; armed = 1'b0; cnt = 0; inFrame = 1'b0;
            end else if (forceMode) begin
                engBusy = forceBusy;
                engRx   = forceRx;
            end else if (engBusy) begin
                if (cnt == 1) begin
                    engBusy  = 1'b0;
                    engRx    = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hEE;
                    lastFall = cycles;
                    check("tx_byte_stable", mTx, capTx);
                end else begin
                    cnt--;
                end
            end else if (armed) begin
                engBusy = 1'b1;
                cnt     = busyLen;
                armed   = 1'b0;
            end else if (mGet) begin
                armed = 1'b1;
                capTx = mTx;
                if (inFrame) check("gap_cycles", cycles - lastFall, expGap);
                else capIdx = 0;
                inFrame = 1'b1;
                capIdx++;
                if (txExp.size() > 0) check("tx_byte", mTx, txExp.pop_front());
                else timeout_fail("tx_byte_extra", 0);
            end
            if (inFrame && mSs && !mDone && !mAbort) ssViol++;
            if (mDone || mAbort) inFrame = 1'b0;
        end
    end

    // Scoreboard monitor: every done/aborted pulse is matched against the next expected event.
    typedef struct {
        bit          isAbort;
        logic [39:0] data;
    } evt_t;
    evt_t expQ[$];
    int   doneCnt  = 0;
    int   abortCnt = 0;

    initial begin
        evt_t e;
        forever begin
            @(negedge CLK);
            if (mDone || mAbort) begin
                if (mDone)  doneCnt++;
                if (mAbort) abortCnt++;
                if (expQ.size() == 0) begin
                    check("unexpected_event", {mDone, mAbort}, 2'b00);
                end else begin
                    e = expQ.pop_front();
                    check("event_kind", mAbort, e.isAbort);
                    check(e.isAbort ? "abort_dout" : "done_dout", mDout, e.data);
                    check("event_ss_n", mSs, 1'b1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic prep(input logic [39:0] tx, input int nb, input logic [39:0] rx);
        txExp.delete();
        rxQ.delete();
        for (int i = 0; i < nb; i++) begin
            txExp.push_back(tx[(nb-1-i)*8 +: 8]);
            rxQ.push_back(rx[(nb-1-i)*8 +: 8]);
        end
        txFrame = tx;
    endtask

    task automatic expect_evt(input bit isAbort, input logic [39:0] data);
        evt_t e;
        e.isAbort = isAbort;
        e.data    = data;
        expQ.push_back(e);
    endtask

    task automatic wait_evt(input string name, input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (!(mDone || mAbort) && waited < limit);
        if (!(mDone || mAbort)) timeout_fail(name, limit);
        #1;
    endtask

    task automatic wait_cap(input string name, input int idx);
        int n;
        n = 0;
        while (!(capIdx == idx && engBusy) && n < 200) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 200) timeout_fail(name, 200);
    endtask

    initial begin
        int waited, doneBefore;
        sel = 0; RST = 1'b1; start = 1'b0; abort = 1'b0; txFrame = '0;
        tick(3);
        check("rst_ss_n", mSs, 1'b1);
        check("rst_get_byte", mGet, 1'b0);
        check("rst_tx_byte", mTx, 8'h00);
        check("rst_dout", mDout, 40'h0);
        check("rst_done", mDone, 1'b0);
        check("rst_frame_busy", mFbusy, 1'b0);
        check("rst_aborted", mAbort, 1'b0);
        RST = 1'b0;
        tick(2);

        // Held start: one frame only; tx_frame changes after latching are ignored.
        prep(40'hA1B2C3D4E5, 5, 40'h0102030405);
        expect_evt(1'b0, 40'h0102030405);
        doneBefore = doneCnt;
        start = 1'b1;
        tick(1);
        check("ss_fall_latency", mSs, 1'b0);
        check("frame_busy_active", mFbusy, 1'b1);
        txFrame = 40'hFFFFFFFFFF;
        wait_evt("held_frame", 100, waited);
        check("frame_latency", 1 + waited, 5 * (busyLen + 3) + 1);
        tick(168);
        check("held_start_one_done", doneCnt - doneBefore, 1);
        check("held_in_done", mFbusy, 1'b1);
        start = 1'b0;
        tick(2);
        check("release_to_idle", mFbusy, 1'b0);

        // Joystick frame after re-asserting start.
        prep(40'h8000000000, 5, 40'h1122334455);
        expect_evt(1'b0, 40'h1122334455);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_evt("joystick_frame", 100, waited);
        check("joystick_done_count", doneCnt - doneBefore, 2);
        tick(2);

        // start and abort together in IDLE: abort wins silently.
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", mFbusy, 1'b0);
        tick(2);
        check("start_abort_no_pulse", abortCnt, 0);

        // Abort during XFER of byte 2: byte completes, then IDLE with aborted pulse.
        prep(40'h0102030405, 5, 40'hAABBCCDDEE);
        expect_evt(1'b1, 40'h1122334455);
        doneBefore = doneCnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_cap("abort_reach_byte2", 2);
        @(negedge CLK);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_evt("abort_xfer", 20, waited);
        check("abort_after_busy_fall", cycles - lastFall, 1);
        check("abort_frame_busy", mFbusy, 1'b0);
        check("abort_no_done", doneCnt - doneBefore, 0);
        tick(3);

        // Reset during byte 3, then a fresh full frame.
        prep(40'h0102030405, 5, 40'h0A0B0C0D0E);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_cap("reset_reach_byte3", 3);
        @(negedge CLK);
        RST = 1'b1;
        tick(1);
        check("midrst_ss_n", mSs, 1'b1);
        check("midrst_get_byte", mGet, 1'b0);
        check("midrst_dout", mDout, 40'h0);
        check("midrst_frame_busy", mFbusy, 1'b0);
        tick(1);
        RST = 1'b0;
        tick(2);
        prep(40'h8000000000, 5, 40'h1122334455);
        expect_evt(1'b0, 40'h1122334455);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_evt("post_reset_frame", 100, waited);
        tick(3);

        // Gap configuration: 3 bytes, 4 idle cycles between bytes.
        sel = 1; busyLen = 2; expGap = 4 + 2;
        tick(1);
        prep(40'h0A0B0C, 3, 40'hC1C2C3);
        expect_evt(1'b0, 40'hC1C2C3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_evt("gap_frame", 100, waited);
        check("gap_frame_latency", 1 + waited, 3 * (busyLen + 3) + 2 * 4 + 1);
        tick(3);

        // Single-byte configuration with busy already high when REQ is entered.
        sel = 2; forceMode = 1'b1; forceBusy = 1'b1; forceRx = 8'h5A;
        txFrame = 40'h3C;
        tick(2);
        expect_evt(1'b0, 40'h5A);
        doneBefore = doneCnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("edge_get_byte_high", mGet, 1'b1);
        check("edge_tx_byte", mTx, 8'h3C);
        tick(1);
        check("edge_get_byte_one_cycle", mGet, 1'b0);
        check("edge_ss_n_low", mSs, 1'b0);
        tick(2);
        forceBusy = 1'b0;
        wait_evt("edge_frame", 20, waited);
        check("edge_done_count", doneCnt - doneBefore, 1);
        forceMode = 1'b0;
        tick(3);

        check("ss_n_low_in_frame", ssViol, 0);
        check("events_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
